count_enable_gen: RTL and testbench
===================================

# count_enable_gen

Programmable enable-pulse generator sitting directly upstream of the counter block; its `tick` output drives the counters' `enable` input. Divides `clk` by a runtime value latched at start and emits one-cycle pulses, either free-running until stopped or, when compiled in, for a fixed burst count. Reports run status (`busy`) and burst completion (`done`) to the controlling logic.

## Interface
- `DIV_WIDTH`, 8: width of the divide value and prescaler counter
- `BURST_WIDTH`, 8: width of the burst length and tick counter
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: level-sampled; begins a run when sampled in IDLE
- `stop` in 1: level-sampled; aborts a run
- `burst_mode` in 1: 1 = burst run, 0 = free-run; latched at start
- `div_val` in DIV_WIDTH: divide ratio N, latched at start
- `burst_len` in BURST_WIDTH: number of ticks per burst, latched at start
- `tick` out 1: registered one-cycle enable pulse, period N
- `busy` out 1: high while state is RUN
- `done` out 1: registered one-cycle pulse on burst completion

## Operation
- Reset: state IDLE, prescaler 0, tick counter 0, `tick`=0, `busy`=0, `done`=0. Reset mid-run aborts immediately with no `done`.
- States: IDLE, RUN.
- IDLE -> RUN: `start`=1 and `stop`=0 at an edge (t0); latch `div_val`, `burst_len`, `burst_mode`; prescaler <= 0.
- `div_val`=0 is treated as N=1.
- RUN, each edge: if prescaler==N-1 then prescaler <= 0, `tick` <= 1; else prescaler <= prescaler+1, `tick` <= 0.
- Burst mode: count issued ticks; the edge issuing tick number `burst_len` also sets `done` <= 1 and state <= IDLE. `burst_len`=0: no ticks; `done` set at t0+1, return to IDLE.
- RUN -> IDLE on `stop`=1 at an edge: `tick` <= 0, `done` <= 0, prescaler cleared. Stop overrides a tick/completion due at the same edge.
- `start` during RUN ignored (no restart); input changes during RUN ignored (latched values used).
- `start` and `stop` both high in IDLE: stay IDLE.
- Prescaler and tick counter wrap never occurs: bounded by N-1 and `burst_len`.

## Timing
- First `tick` high in the cycle after edge t0+N; subsequent ticks every N cycles.
- N=1: `tick` continuously high from t0+1 until stop/completion.
- `busy` high from t0 to the edge that returns to IDLE; low in the cycle `done` is high.
- `done` coincides with the final `tick` cycle.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `COUNT_ENABLE_GEN_BURST_EN` defined: burst mode, tick counter, and `done` logic present as above.
- Not defined: free-run only; `burst_mode` and `burst_len` ignored, tick counter absent, `done` tied 0; run ends only on `stop` or `reset`.

## Structure
- Package `count_enable_gen_pkg`: state enum (IDLE, RUN), default `DIV_WIDTH`/`BURST_WIDTH` constants.
- One sub-module `enable_prescaler`: latched divide value, prescaler counter, terminal-count flag; FSM, burst count and output registers in the top.

## Test plan
- Reset asserted mid-run (N=4, free-run) -> `tick`, `busy`, `done` all 0 immediately; stays IDLE after release until `start`.
- Free-run, `div_val`=4, start at t0 -> `tick` high at t0+4, t0+8, t0+12; `stop` at t0+10 -> no tick at t0+12, `busy` low after t0+10.
- `div_val`=0 and `div_val`=1, free-run -> `tick` continuously high from t0+1.
- Burst (macro on), `div_val`=3, `burst_len`=5 -> exactly 5 ticks at t0+3..t0+15, `done` high with the 5th, `busy` low then; `burst_len`=0 -> zero ticks, `done` at t0+1.
- Stop at the edge of the final burst tick -> no final tick, no `done`; `start` and `stop` together in IDLE -> remains IDLE.
- `start` re-asserted and `div_val` changed mid-run -> period unchanged, no restart; macro off build -> `done` always 0, burst inputs ignored.

Source files
------------

// File: rtl/count_enable_gen_pkg.sv
// count_enable_gen_pkg
// Shared types and default widths for the count_enable_gen block.
//   state_e          : run-control FSM states (IDLE, RUN)
//   DEF_DIV_WIDTH    : default width of the divide value / prescaler counter
//   DEF_BURST_WIDTH  : default width of the burst length / tick counter
package count_enable_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_DIV_WIDTH   = 8;
  localparam int DEF_BURST_WIDTH = 8;

endpackage

// File: rtl/count_enable_gen_if.sv
// count_enable_gen_if
// Control/status bundle between the controlling logic (master) and the
// enable generator (slave).
//   start, stop  : level-sampled run control
//   burst_mode   : 1 = burst run, 0 = free-run (latched at start)
//   div_val      : divide ratio N (0 behaves as 1), latched at start
//   burst_len    : ticks per burst, latched at start
//   tick         : registered one-cycle enable pulse, period N
//   busy         : high while the generator is running
//   done         : registered one-cycle pulse on burst completion
interface count_enable_gen_if
  import count_enable_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH
);

  logic                   start;
  logic                   stop;
  logic                   burst_mode;
  logic [DIV_WIDTH-1:0]   div_val;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   tick;
  logic                   busy;
  logic                   done;

  modport master (
    output start, stop, burst_mode, div_val, burst_len,
    input  tick, busy, done
  );

  modport slave (
    input  start, stop, burst_mode, div_val, burst_len,
    output tick, busy, done
  );

endinterface

// File: rtl/enable_prescaler.sv
// enable_prescaler
// Holds the divide value latched at run start and counts clock cycles,
// flagging the terminal count once every N cycles while running.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture div_val (asserted on the start edge)
//   run        : counting enabled; when low the counter is held at 0
//   div_val    : divide ratio N; 0 is treated as 1
//   tc         : terminal count (counter == N-1) while running
module enable_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div_val,
  output logic                 tc
);

  logic [DIV_WIDTH-1:0] term_q;
  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term_q <= '0;
      cnt_q  <= '0;
    end else begin
      // N-1 is stored so N=0 and N=1 both give a terminal value of 0.
      if (load)
        term_q <= (div_val == '0) ? '0 : div_val - DIV_WIDTH'(1);
      if (!run || tc)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

  assign tc = run && (cnt_q == term_q);

endmodule

// File: rtl/count_enable_gen.sv
// count_enable_gen
// Programmable enable-pulse generator feeding the counters' enable input.
// Divides clk by a value latched at start and emits one-cycle tick pulses,
// free-running until stopped or, with COUNT_ENABLE_GEN_BURST_EN defined,
// for a fixed burst count ending with a done pulse.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : count_enable_gen_if.slave (start/stop/burst_mode/div_val/
//                burst_len in; tick/busy/done out)
// Build option: `define COUNT_ENABLE_GEN_BURST_EN to include burst mode;
// otherwise burst_mode/burst_len are ignored and done is tied low.
module count_enable_gen
  import count_enable_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  count_enable_gen_if.slave    bus
);

  state_e state_q, state_d;
  logic   tick_q, tick_d;
  logic   load;
  logic   run;
  logic   tc;

  assign load = (state_q == IDLE) && bus.start && !bus.stop;
  // Dropping run on stop clears the prescaler on the same edge.
  assign run  = (state_q == RUN) && !bus.stop;

  enable_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .run     (run),
    .div_val (bus.div_val),
    .tc      (tc)
  );

`ifdef COUNT_ENABLE_GEN_BURST_EN
  logic                   mode_q, mode_d;
  logic [BURST_WIDTH-1:0] len_q, len_d;
  logic [BURST_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    mode_d  = mode_q;
    len_d   = len_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = RUN;
          mode_d  = bus.burst_mode;
          len_d   = bus.burst_len;
          tcnt_d  = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (mode_q) begin
          if (len_q == '0) begin
            // Empty burst: finish on the first running edge with no tick.
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (tc) begin
            tick_d = 1'b1;
            tcnt_d = tcnt_q + BURST_WIDTH'(1);
            if (tcnt_q == len_q - BURST_WIDTH'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end else begin
          tick_d = tc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
      len_q  <= '0;
      tcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      len_q  <= len_d;
      tcnt_q <= tcnt_d;
      done_q <= done_d;
    end
  end

  assign bus.done = done_q;
`else
  logic unused_burst;

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: if (load) state_d = RUN;
      RUN: begin
        if (bus.stop)
          state_d = IDLE;
        else
          tick_d = tc;
      end
      default: state_d = IDLE;
    endcase
  end

  assign unused_burst = ^{bus.burst_mode, bus.burst_len};
  assign bus.done     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.tick = tick_q;
  assign bus.busy = (state_q == RUN);

endmodule

// File: tb/tb_count_enable_gen.sv
module tb_count_enable_gen;
  import count_enable_gen_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  count_enable_gen_if bus ();

  count_enable_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Push the expectation for the next edge, advance one cycle, then pop
  // and compare at the falling edge.
  task automatic step(input string tag, input logic t, input logic b, input logic d);
    logic [2:0] e;
    exp_q.push_back({t, b, d});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({tag, ".tick"}, 32'(bus.tick), 32'(e[2]));
    check_val({tag, ".busy"}, 32'(bus.busy), 32'(e[1]));
    check_val({tag, ".done"}, 32'(bus.done), 32'(e[0]));
  endtask

  task automatic set_idle();
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.burst_mode = 1'b0;
    bus.div_val    = '0;
    bus.burst_len  = '0;
  endtask

  // Free-run: start at k=0, stop at k=stop_at. Optional mid-run
  // disturbance re-asserts start and changes every input.
  task automatic run_free(input string tag, input int div, input int stop_at, input bit perturb);
    int n;
    n = (div == 0) ? 1 : div;
    for (int k = 0; k <= stop_at + 2; k++) begin
      bus.start      = (k == 0);
      bus.stop       = (k == stop_at);
      bus.burst_mode = 1'b0;
      bus.burst_len  = 8'd0;
      bus.div_val    = 8'(div);
      if (perturb && k >= 5 && k <= 7) begin
        bus.start      = 1'b1;
        bus.div_val    = 8'd2;
        bus.burst_mode = 1'b1;
        bus.burst_len  = 8'd1;
      end
      if (k == 0)
        step(tag, 1'b0, 1'b1, 1'b0);
      else if (k < stop_at)
        step(tag, (k % n) == 0, 1'b1, 1'b0);
      else
        step(tag, 1'b0, 1'b0, 1'b0);
    end
    set_idle();
  endtask

  // Burst request: start at k=0, stop asserted at k=stop_at (which may
  // fall after completion, where it must have no effect).
  task automatic run_burst(input string tag, input int div, input int len, input int stop_at);
    int n;
    int end_k;
    logic t, b, d;
    n     = (div == 0) ? 1 : div;
    end_k = (len == 0) ? 1 : n * len;
    for (int k = 0; k <= stop_at + 2; k++) begin
      bus.start      = (k == 0);
      bus.stop       = (k == stop_at);
      bus.burst_mode = 1'b1;
      bus.burst_len  = 8'(len);
      bus.div_val    = 8'(div);
`ifdef COUNT_ENABLE_GEN_BURST_EN
      t = (k >= 1) && (k < stop_at) && (k <= end_k) && (len > 0) && ((k % n) == 0);
      d = (k == end_k) && (k < stop_at);
      b = (k < stop_at) && (k < end_k);
`else
      t = (k >= 1) && (k < stop_at) && ((k % n) == 0);
      d = 1'b0;
      b = (k < stop_at);
`endif
      step(tag, t, b, d);
    end
    set_idle();
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    #1;
    check_val("rst.tick", 32'(bus.tick), 32'd0);
    check_val("rst.busy", 32'(bus.busy), 32'd0);
    check_val("rst.done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step("idle", 1'b0, 1'b0, 1'b0);

    run_free("free4", 4, 10, 1'b0);
    run_free("free0", 0, 6, 1'b0);
    run_free("free1", 1, 6, 1'b0);
    run_free("free3_dist", 3, 12, 1'b1);

    run_burst("burst3x5", 3, 5, 20);
    run_burst("burst3x0", 3, 0, 5);
    run_burst("burst3x5_stop", 3, 5, 15);
    run_burst("burst2x3", 2, 3, 10);

    // start and stop together while idle: no run.
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    bus.div_val = 8'd2;
    for (int k = 0; k < 4; k++) step("startstop", 1'b0, 1'b0, 1'b0);
    set_idle();
    for (int k = 0; k < 3; k++) step("startstop_after", 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-run, right after a tick has been issued.
    bus.start   = 1'b1;
    bus.div_val = 8'd4;
    step("mid_rst_run", 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) step("mid_rst_run", k == 4, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst.tick", 32'(bus.tick), 32'd0);
    check_val("mid_rst.busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst.done", 32'(bus.done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) step("post_rst", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
